ewb_coalesce_buf: RTL

//  Parametrised eviction write buffer between the L2 cache and main memory.

---
 rtl/ewb_coalesce_buf.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ewb_coalesce_buf.sv
// Eviction write buffer: FIFO of dirty victim lines with a combinational snoop lookup by line address.
// Latency: an accepted line appears on deq_* and snoop_* the cycle after acceptance; snoop itself is combinational.
// Backpressure: enq_ready_o drops when full (unless coalescing into a pending line); head leaves on deq_yumi_i.
// Optional: define EWB_COALESCE_EN to merge same-line enqueues into the pending entry.
module ewb_coalesce_buf #(
    parameter int WIDTH    = 256,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5,
    localparam int LINE_W  = ADDR_W - OFFSET_W,
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_valid_i,
    output logic              enq_ready_o,
    input  logic [ADDR_W-1:0] enq_addr_i,
    input  logic [WIDTH-1:0]  enq_data_i,
    input  logic              snoop_valid_i,
    input  logic [LINE_W-1:0] snoop_line_i,
    output logic              snoop_hit_o,
    output logic [WIDTH-1:0]  snoop_data_o,
    output logic              deq_valid_o,
    output logic [ADDR_W-1:0] deq_addr_o,
    output logic [WIDTH-1:0]  deq_data_o,
    input  logic              deq_yumi_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    // Only the line address is kept: the offset is always driven as zero on the way out.
    logic [LINE_W-1:0] line_q [DEPTH];
    logic [LINE_W-1:0] line_d [DEPTH];
    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [WIDTH-1:0]  data_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [LINE_W-1:0] enq_line;
    logic              enq_fire;
    logic              deq_fire;
    logic              do_coal;
    logic              alloc;
    logic [PTR_W-1:0]  coal_idx;
    logic              unused_enq_offset;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign enq_line          = enq_addr_i[ADDR_W-1:OFFSET_W];
    assign unused_enq_offset = ^enq_addr_i[OFFSET_W-1:0];

    assign count_o     = count_q;
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign deq_valid_o = !empty_o;
    assign deq_addr_o  = empty_o ? '0 : {line_q[head_q], {OFFSET_W{1'b0}}};
    assign deq_data_o  = empty_o ? '0 : data_q[head_q];

    assign deq_fire = deq_yumi_i && deq_valid_o;
    assign enq_fire = enq_valid_i && enq_ready_o;
    assign alloc    = enq_fire && !do_coal;

`ifdef EWB_COALESCE_EN
    logic coal_hit;

    // Find the pending entry holding the enqueue's line (at most one exists when merging).
    always_comb begin
        logic [PTR_W-1:0] idx;
        coal_hit = 1'b0;
        coal_idx = '0;
        idx      = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_q[idx] && line_q[idx] == enq_line) begin
                coal_hit = 1'b1;
                coal_idx = idx;
            end
            idx = ptr_inc(idx);
        end
    end

    // A head that leaves this cycle cannot absorb the write, so the line is allocated fresh at the tail.
    assign enq_ready_o = !full_o || coal_hit;
    assign do_coal     = enq_fire && coal_hit && !(coal_idx == head_q && deq_fire);
`else
    assign coal_idx    = '0;
    assign enq_ready_o = !full_o;
    assign do_coal     = 1'b0;
`endif

    // Snoop walks oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        logic [PTR_W-1:0] idx;
        snoop_hit_o  = 1'b0;
        snoop_data_o = '0;
        idx          = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (snoop_valid_i && vld_q[idx] && line_q[idx] == snoop_line_i) begin
                snoop_hit_o  = 1'b1;
                snoop_data_o = data_q[idx];
            end
            idx = ptr_inc(idx);
        end
    end

    // Next-state: dequeue clears the head first so a full-buffer allocate into the same slot wins.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        vld_d   = vld_q;
        line_d  = line_q;
        data_d  = data_q;
        if (deq_fire) begin
            vld_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end
        if (do_coal) begin
            data_d[coal_idx] = enq_data_i;
        end else if (enq_fire) begin
            line_d[tail_q] = enq_line;
            data_d[tail_q] = enq_data_i;
            vld_d[tail_q]  = 1'b1;
            tail_d         = ptr_inc(tail_q);
        end
        count_d = count_q + CNT_W'(alloc) - CNT_W'(deq_fire);
    end

    // Control state: pointers, occupancy and valid bits are cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Line storage is not reset; the valid bits gate every read of it.
    always_ff @(posedge clk) begin
        line_q <= line_d;
        data_q <= data_d;
    end

endmodule
